// File: rtl/data_gen_pkg.sv
// Shared constants and types for the packet stimulus source:
// LFSR seed/taps, descriptor field layout and the sender FSM states.
package data_gen_pkg;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 6;
    localparam int START_LSB = 13;
    localparam int START_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOP,
        S_HDR,
        S_PAY,
        S_EOP
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous descriptor FIFO; rd_data is registered and holds the popped
// word from the cycle after the pop.
module sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == {1'b1, {ADDR_W{1'b0}}});
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_gen_wrapper.sv
// Self-contained packet source: LFSR descriptors feed a FIFO, and a sender
// FSM frames each one as sop, header, payload beats from RAM, eop.
module data_gen_wrapper
    import data_gen_pkg::*;
#(
    parameter int GEN_INF_W   = 32,
    parameter int FIFO_ADDR_W = 5,
    parameter int RAM_ADDR_W  = 5,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [15:0]   fetch_n,
    output logic          o_sop,
    output logic          o_vld,
    output logic [DW-1:0] o_data,
    output logic          o_eop
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;
    localparam int BYTES     = DW / 8;

    state_t                state;
    state_t                state_nxt;
    logic [31:0]           lfsr;
    logic [31:0]           lfsr_next;
    logic [RAM_ADDR_W-1:0] init_cnt;
    logic                  init_done;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [GEN_INF_W-1:0]  fifo_rd;
    logic [GEN_INF_W-1:0]  desc_q;
    logic [DW-1:0]         ram [RAM_DEPTH];
    logic [DW-1:0]         ram_q;
    logic [RAM_ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]      beat_cnt;
    logic [LEN_W-1:0]      len_m1;
    logic [START_W-1:0]    start_f;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);
    assign push      = init_done && !fifo_full;
    assign len_m1    = desc_q[LEN_LSB +: LEN_W];
    assign start_f   = fifo_rd[START_LSB +: START_W];

    sync_fifo #(
        .WIDTH  (GEN_INF_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (lfsr[GEN_INF_W-1:0]),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The read port runs every cycle; rd_addr is aimed one beat ahead so
    // payload beats come out back-to-back.
    always_ff @(posedge clk) begin
        if (!rst_n && !init_done) begin
            ram[init_cnt] <= {BYTES{8'(init_cnt)}};
        end
        ram_q <= ram[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
            lfsr      <= LFSR_SEED;
            fetch_n   <= '0;
            desc_q    <= '0;
            rd_addr   <= '0;
            beat_cnt  <= '0;
        end else begin
            if (!init_done) begin
                init_cnt <= init_cnt + 1'b1;
                if (&init_cnt) begin
                    init_done <= 1'b1;
                end
            end
            if (push) begin
                lfsr <= lfsr_next;
            end
            if (pop) begin
                fetch_n <= fetch_n + 1'b1;
            end
            if (state == S_SOP) begin
                desc_q  <= fifo_rd;
                rd_addr <= start_f[RAM_ADDR_W-1:0];
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
            if (state == S_HDR) begin
                beat_cnt <= '0;
            end else if (state == S_PAY) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        o_sop     = 1'b0;
        o_vld     = 1'b0;
        o_eop     = 1'b0;
        o_data    = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SOP;
                end
            end
            S_SOP: begin
                o_sop     = 1'b1;
                state_nxt = S_HDR;
            end
            S_HDR: begin
                o_vld     = 1'b1;
                o_data    = DW'(desc_q);
                state_nxt = S_PAY;
            end
            S_PAY: begin
                o_vld  = 1'b1;
                o_data = ram_q;
                if (beat_cnt == len_m1) begin
                    state_nxt = S_EOP;
                end
            end
            S_EOP: begin
                o_eop     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_gen_wrapper.sv
// Bench for data_gen_wrapper: startup timing table, long-run packet parsing
// against an LFSR/RAM reference model, and a randomly placed mid-packet reset.
module tb_data_gen_wrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fetch_n;
    logic        o_sop;
    logic        o_vld;
    logic [31:0] o_data;
    logic        o_eop;

    int n_cmp = 0;
    int n_bad = 0;
    int full_cycles = 0;

    localparam int RUN = 1000;

    logic        rec_sop   [RUN];
    logic        rec_vld   [RUN];
    logic        rec_eop   [RUN];
    logic [31:0] rec_data  [RUN];
    logic [15:0] rec_fetch [RUN];

    data_gen_wrapper dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fetch_n (fetch_n),
        .o_sop   (o_sop),
        .o_vld   (o_vld),
        .o_data  (o_data),
        .o_eop   (o_eop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.u_fifo.full) begin
            full_cycles <= full_cycles + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsrStep(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] ramWord(input int addr);
        logic [7:0] b;
        b = 8'(addr % 32);
        return {4{b}};
    endfunction

    // Hold reset across two rising edges, then release just after the second.
    task automatic applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    task automatic checkStartup(input string pfx);
        int busy;
        logic [2:0]  t_ctl   [9];
        logic [31:0] t_data  [9];
        logic [15:0] t_fetch [9];
        t_ctl   = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b000, 3'b100, 3'b010, 3'b010, 3'b001};
        t_data  = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8020_0003, 32'h0, 32'h0};
        t_fetch = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
        busy = 0;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checkOutput({pfx, "reset_state"}, 64'({o_sop, o_vld, o_eop, o_data, fetch_n}), 64'd0);
            end
            if (o_sop || o_vld || o_eop) busy++;
        end
        checkOutput({pfx, "init_quiet"}, 64'(busy), 64'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checkOutput($sformatf("%sctl@%0d", pfx, 34 + i), 64'({o_sop, o_vld, o_eop}), 64'(t_ctl[i]));
            checkOutput($sformatf("%sfetch@%0d", pfx, 34 + i), 64'(fetch_n), 64'(t_fetch[i]));
            if (t_ctl[i][1]) begin
                checkOutput($sformatf("%sdata@%0d", pfx, 34 + i), 64'(o_data), 64'(t_data[i]));
            end
        end
    endtask

    task automatic checkLongRun();
        int idx;
        int pkts;
        int len;
        int start;
        int fc0;
        logic [31:0] exp_hdr;
        logic [31:0] hdr;
        fc0 = full_cycles;
        for (int c = 0; c < RUN; c++) begin
            @(negedge clk);
            rec_sop[c]   = o_sop;
            rec_vld[c]   = o_vld;
            rec_eop[c]   = o_eop;
            rec_data[c]  = o_data;
            rec_fetch[c] = fetch_n;
        end
        checkOutput("fifo_full_seen", 64'(full_cycles > fc0), 64'd1);
        idx = 34;
        pkts = 0;
        exp_hdr = 32'h1;
        while (idx + 1 < RUN) begin
            checkOutput($sformatf("sop@%0d", idx), 64'({rec_sop[idx], rec_vld[idx], rec_eop[idx]}), 64'(3'b100));
            if (!rec_sop[idx]) break;
            pkts++;
            checkOutput($sformatf("fetch@%0d", idx), 64'(rec_fetch[idx]), 64'(16'(pkts)));
            hdr = rec_data[idx + 1];
            checkOutput($sformatf("hdr_ctl@%0d", idx + 1), 64'({rec_sop[idx + 1], rec_vld[idx + 1], rec_eop[idx + 1]}), 64'(3'b010));
            checkOutput($sformatf("hdr@%0d", idx + 1), 64'(hdr), 64'(exp_hdr));
            if (hdr !== exp_hdr) break;
            len   = int'(hdr[12:7]) + 1;
            start = int'(hdr[17:13]);
            if (idx + len + 4 >= RUN) break;
            for (int k = 0; k < len; k++) begin
                checkOutput($sformatf("pay_ctl@%0d", idx + 2 + k), 64'({rec_sop[idx + 2 + k], rec_vld[idx + 2 + k], rec_eop[idx + 2 + k]}), 64'(3'b010));
                checkOutput($sformatf("pay@%0d", idx + 2 + k), 64'(rec_data[idx + 2 + k]), 64'(ramWord(start + k)));
            end
            checkOutput($sformatf("eop@%0d", idx + 2 + len), 64'({rec_sop[idx + 2 + len], rec_vld[idx + 2 + len], rec_eop[idx + 2 + len]}), 64'(3'b001));
            checkOutput($sformatf("idle@%0d", idx + 3 + len), 64'({rec_sop[idx + 3 + len], rec_vld[idx + 3 + len], rec_eop[idx + 3 + len]}), 64'(3'b000));
            idx = idx + len + 4;
            exp_hdr = lfsrStep(exp_hdr);
        end
        checkOutput("enough_packets", 64'(pkts >= 10), 64'd1);
    endtask

    task automatic checkMidReset();
        logic prev_sop;
        logic found;
        prev_sop = 1'b1;
        found = 1'b0;
        repeat ($urandom_range(0, 200)) @(negedge clk);
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (o_vld && !prev_sop) found = 1'b1;
            prev_sop = o_sop;
        end
        checkOutput("pay_found", 64'(found), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_clear", 64'({o_sop, o_vld, o_eop, o_data, fetch_n}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        checkStartup("rst2_");
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus();
        checkStartup("");
        applyStimulus();
        checkLongRun();
        checkMidReset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_gen_wrapper.md
Name: data_gen_wrapper

Overview:
Self-contained packet stimulus source for the multi-port cache datapath.
- An LFSR produces packet descriptors into an internal FIFO.
- A sender FSM pops each descriptor and emits one framed packet on a sop/vld/data/eop stream: a header beat followed by payload beats read from a payload RAM.
- Counts fetched descriptors on fetch_n.

Parameters:
- GEN_INF_W, 32: descriptor width; must be ≥ 18.
- FIFO_ADDR_W, 5: descriptor FIFO depth is 2^FIFO_ADDR_W.
- RAM_ADDR_W, 5: payload RAM depth is 2^RAM_ADDR_W; must be ≤ 5.
- DW, 32: output data width; multiple of 8, ≥ GEN_INF_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-high reset; port keeps the codebase name.
- fetch_n  out  16  number of descriptors popped since reset; wraps modulo 2^16.
- o_sop  out  1  one-cycle start-of-packet pulse.
- o_vld  out  1  data beat valid.
- o_data  out  DW  beat data.
- o_eop  out  1  one-cycle end-of-packet pulse.

Behaviour:
- Reset, sampled on clk when rst_n=1:
  - All outputs go to 0 and fetch_n to 0.
  - FIFO is emptied, LFSR is loaded with 1, and the init phase restarts.
  - Reset mid-packet aborts the packet; no eop is emitted.
- Init phase: starts the first cycle after reset releases and lasts 2^RAM_ADDR_W cycles. Cycle i writes ram[i] = the 8-bit zero-extended value of i, replicated DW/8 times. Nothing is pushed or sent during init.
- LFSR: 32-bit Galois, shift right, tap mask 0x80200003.
  - Next = (lfsr>>1) ^ (lfsr[0] ? mask : 0).
  - Descriptor = lfsr[GEN_INF_W-1:0].
- Generator: after init, on each cycle the FIFO is not full, it pushes the current LFSR value and advances the LFSR. Full FIFO stalls the generator and freezes the LFSR.
- Descriptor fields:
  - [3:0] dest port; [6:4] prio; [12:7] len_m1, giving L = len_m1+1 payload beats (1..64).
  - [17:13] start, the RAM base address; upper bits reserved.
- FIFO:
  - Synchronous, show-after-pop: rd_data is registered and valid the cycle after pop.
  - Simultaneous push and pop when full is not allowed, because the generator checks full.
  - Push when empty becomes visible to !empty on the next cycle.
- Sender FSM states:
  - IDLE: if FIFO not empty, pop, increment fetch_n, go to SOP.
  - SOP: o_sop=1; latch the descriptor.
  - HDR: o_vld=1, o_data = descriptor zero-extended to DW.
  - PAY: o_vld=1 for L cycles. Beat k (0..L-1) has o_data = ram[(start+k) mod 2^RAM_ADDR_W]. RAM read is prefetched so beats are back-to-back.
  - EOP: o_eop=1, o_vld=0, then go to IDLE.
- Timing rules:
  - o_sop, o_eop and o_vld are never asserted together.
  - Each packet occupies L+4 cycles: IDLE, SOP, HDR, L×PAY, EOP.
  - There is no backpressure.
- fetch_n is registered and shows its new value the cycle after the pop, i.e. in SOP.

Decomposition:
- Package data_gen_pkg holds:
  - LFSR seed and tap mask;
  - descriptor field offsets and widths;
  - FSM state enum.
- One natural sub-module: sync_fifo, parameterised by width GEN_INF_W and address width FIFO_ADDR_W.
- The payload RAM and LFSR stay inline.

Test Plan:
- Cycle numbering: cycle 0 is the first cycle after rst_n falls.
- Init timing: reset 2 cycles then release. o_sop stays 0 through init (cycles 0–31). First o_sop occurs at cycle 34 and fetch_n=1 the same cycle.
- First packet: header 0x00000001, then exactly one payload beat 0x00000000, then o_eop on the next cycle. Total 4 output cycles: sop, hdr, pay, eop.
- Second packet: header 0x80200003 (port 3, L=1, start 0), payload 0x00000000. o_sop occurs exactly one IDLE cycle after the previous o_eop.
- Long run, 1000 cycles:
  - Every o_sop is followed by exactly 1+L vld beats, then one o_eop, with L taken from header[12:7]+1.
  - Payload beat k equals replicate4(start+k mod 32).
  - fetch_n equals the number of o_sop pulses.
- Full FIFO: checker confirms the FIFO reaches 32 entries while long packets drain. The LFSR sequence in headers remains contiguous, with no skipped or duplicated descriptors.
- Mid-packet reset: rst_n=1 during PAY. Next cycle all outputs and fetch_n are 0. After release, the init and first-packet timing from the first two scenarios repeat exactly.
